// File: rtl/alu_shift_sequencer_if.sv
// Bundle between the microcode sequencer, the shift sequencer and the shared ALU.
// The sequencer uses the slave modport; the requester/ALU side uses master.
interface alu_shift_sequencer_if #(
    parameter int OP_BITS = 5
);
    logic               start;
    logic               abort;
    logic [OP_BITS-1:0] op;
    logic               is_8_bit;
    logic [15:0]        value;
    logic [7:0]         count;
    logic [15:0]        flags_in;
    logic               busy;
    logic               done;
    logic [15:0]        result;
    logic [15:0]        flags_out;
    logic [15:0]        alu_a;
    logic [15:0]        alu_b;
    logic [OP_BITS-1:0] alu_op;
    logic               alu_is_8_bit;
    logic [15:0]        alu_flags_in;
    logic [15:0]        alu_out;
    logic [15:0]        alu_flags_out;

    modport slave (
        input  start, abort, op, is_8_bit, value, count, flags_in,
        input  alu_out, alu_flags_out,
        output busy, done, result, flags_out,
        output alu_a, alu_b, alu_op, alu_is_8_bit, alu_flags_in
    );

    modport master (
        output start, abort, op, is_8_bit, value, count, flags_in,
        output alu_out, alu_flags_out,
        input  busy, done, result, flags_out,
        input  alu_a, alu_b, alu_op, alu_is_8_bit, alu_flags_in
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Runs a multi-bit shift/rotate as a chain of single-bit ALU steps, feeding the
// ALU result back into a working value/flags register once per cycle.
//
// state  | meaning
// S_IDLE | waiting for start; registers hold last result
// S_RUN  | one ALU step per cycle until remaining reaches zero
// S_DONE | one-cycle done pulse, result/flags stable
module alu_shift_sequencer #(
    parameter int OP_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        value_q, value_d;
    logic [15:0]        flags_q, flags_d;
    logic [4:0]         remaining_q, remaining_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic               w8_q, w8_d;
    logic               unused_count_hi;

    // Only the 5-bit count matters; the upper count bits are architecturally ignored.
    assign unused_count_hi = ^bus.count[7:5];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            value_q     <= 16'd0;
            flags_q     <= 16'd0;
            remaining_q <= 5'd0;
            op_q        <= '0;
            w8_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            flags_q     <= flags_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            w8_q        <= w8_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        flags_d     = flags_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        w8_d        = w8_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    op_d        = bus.op;
                    w8_d        = bus.is_8_bit;
                    value_d     = bus.value;
                    flags_d     = bus.flags_in;
                    remaining_d = bus.count[4:0];
                    state_d     = (bus.count[4:0] == 5'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort freezes the partial value rather than taking this step.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    value_d     = bus.alu_out;
                    flags_d     = bus.alu_flags_out;
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q <= 5'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE) && !bus.abort;
    assign bus.result       = value_q;
    assign bus.flags_out    = flags_q;
    assign bus.alu_a        = value_q;
    assign bus.alu_b        = 16'd1;
    assign bus.alu_op       = op_q;
    assign bus.alu_is_8_bit = w8_q;
    assign bus.alu_flags_in = flags_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: a single-bit ALU stand-in, a closed-form shift
// reference model, directed scenarios and a randomized phase.
module tb_alu_shift_sequencer;
    localparam int OP_BITS = 5;
    localparam logic [4:0] OP_SHL = 5'h08;
    localparam logic [4:0] OP_SHR = 5'h09;
    localparam logic [4:0] OP_SAR = 5'h0A;
    localparam logic [4:0] OP_ROL = 5'h0B;
    localparam logic [4:0] OP_ROR = 5'h0C;
    localparam logic [4:0] OP_RCL = 5'h0D;
    localparam logic [4:0] OP_RCR = 5'h0E;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [4:0] ops [7];

    always #5 clk = ~clk;

    alu_shift_sequencer_if #(.OP_BITS(OP_BITS)) bus ();
    alu_shift_sequencer #(.OP_BITS(OP_BITS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // Single-bit ALU: operates on the low byte in 8-bit mode, upper byte passes through.
    logic [15:0] am_mask, am_v, am_r, am_top;
    logic        am_msb, am_co;
    always_comb begin
        am_mask = bus.alu_is_8_bit ? 16'h00FF : 16'hFFFF;
        am_top  = bus.alu_is_8_bit ? 16'h0080 : 16'h8000;
        am_v    = bus.alu_a & am_mask;
        am_msb  = bus.alu_is_8_bit ? am_v[7] : am_v[15];
        am_r    = am_v;
        am_co   = bus.alu_flags_in[0];
        case (bus.alu_op)
            OP_SHL: begin am_r = am_v << 1; am_co = am_msb; end
            OP_SHR: begin am_r = am_v >> 1; am_co = am_v[0]; end
            OP_SAR: begin am_r = (am_v >> 1) | (am_msb ? am_top : 16'h0); am_co = am_v[0]; end
            OP_ROL: begin am_r = (am_v << 1) | {15'b0, am_msb}; am_co = am_msb; end
            OP_ROR: begin am_r = (am_v >> 1) | (am_v[0] ? am_top : 16'h0); am_co = am_v[0]; end
            OP_RCL: begin am_r = (am_v << 1) | {15'b0, bus.alu_flags_in[0]}; am_co = am_msb; end
            OP_RCR: begin am_r = (am_v >> 1) | (bus.alu_flags_in[0] ? am_top : 16'h0); am_co = am_v[0]; end
            default: ;
        endcase
        bus.alu_out       = (bus.alu_a & ~am_mask) | (am_r & am_mask);
        bus.alu_flags_out = {bus.alu_flags_in[15:1], am_co};
    end

    // Closed-form n-bit shift/rotate; returns {flags, value}. CF lives in flags bit 0.
    function automatic logic [31:0] ref_shift(input logic [4:0] op, input logic w8,
                                              input logic [15:0] val, input logic [15:0] flg,
                                              input int n);
        longint unsigned w, w1, mask, m1, v, x, r, res, cf, k;
        longint signed   s;
        logic [15:0]     full;
        if (n == 0) return {flg, val};
        w    = w8 ? 64'd8 : 64'd16;
        w1   = w + 64'd1;
        mask = (64'd1 << w) - 64'd1;
        m1   = (64'd1 << w1) - 64'd1;
        v    = longint'(val) & mask;
        cf   = longint'(flg[0]);
        res  = v;
        x    = (cf << w) | v;
        s    = w8 ? longint'($signed(val[7:0])) : longint'($signed(val));
        case (op)
            OP_SHL: begin r = v << n; res = r & mask; cf = (r >> w) & 64'd1; end
            OP_SHR: begin res = v >> n; cf = (v >> (n - 1)) & 64'd1; end
            OP_SAR: begin res = longint'(s >>> n) & mask; cf = longint'(s >>> (n - 1)) & 64'd1; end
            OP_ROL: begin k = longint'(n) % w; res = ((v << k) | (v >> (w - k))) & mask; cf = res & 64'd1; end
            OP_ROR: begin k = longint'(n) % w; res = ((v >> k) | (v << (w - k))) & mask; cf = (res >> (w - 64'd1)) & 64'd1; end
            OP_RCL: begin k = longint'(n) % w1; r = ((x << k) | (x >> (w1 - k))) & m1; res = r & mask; cf = (r >> w) & 64'd1; end
            OP_RCR: begin k = longint'(n) % w1; r = ((x >> k) | (x << (w1 - k))) & m1; res = r & mask; cf = (r >> w) & 64'd1; end
            default: ;
        endcase
        full = (val & ~mask[15:0]) | res[15:0];
        return {flg[15:1], cf[0], full};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which operation is live and how many single-bit steps it has taken.
    logic        m_active;
    int          m_n, m_k;
    logic [15:0] m_val, m_flg;
    logic [4:0]  m_op;
    logic        m_w8;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0; m_n = 0; m_k = 0;
            m_val = 16'h0; m_flg = 16'h0; m_op = 5'h0; m_w8 = 1'b0;
        end else if (!m_active) begin
            if (bus.start && !bus.abort) begin
                m_op = bus.op; m_w8 = bus.is_8_bit; m_val = bus.value; m_flg = bus.flags_in;
                m_n = int'(bus.count[4:0]); m_k = 0; m_active = 1'b1;
            end
        end else if (bus.abort) begin
            m_active = 1'b0;
        end else if (m_k < m_n) begin
            m_k++;
        end else begin
            m_active = 1'b0;
        end
    end

    logic [31:0] m_exp;
    always @(negedge clk) begin
        if (reset_n) begin
            m_exp = ref_shift(m_op, m_w8, m_val, m_flg, m_k);
            chk("busy", {31'b0, bus.busy}, {31'b0, m_active});
            chk("done", {31'b0, bus.done}, {31'b0, m_active && (m_k == m_n) && !bus.abort});
            chk("result", {16'h0, bus.result}, {16'h0, m_exp[15:0]});
            chk("flags_out", {16'h0, bus.flags_out}, {16'h0, m_exp[31:16]});
            chk("alu_a", {16'h0, bus.alu_a}, {16'h0, m_exp[15:0]});
            chk("alu_flags_in", {16'h0, bus.alu_flags_in}, {16'h0, m_exp[31:16]});
            chk("alu_b", {16'h0, bus.alu_b}, 32'h1);
            chk("alu_op", {27'h0, bus.alu_op}, {27'h0, m_op});
            chk("alu_is_8_bit", {31'b0, bus.alu_is_8_bit}, {31'b0, m_w8});
        end
    end

    task automatic run_dir(input string name, input logic [4:0] op, input logic w8,
                           input logic [15:0] val, input logic [7:0] cnt, input logic [15:0] flg,
                           input logic [15:0] exp_res, input logic [15:0] exp_flg,
                           input int exp_lat, input bit poke);
        int lat;
        bit seen;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.abort = 1'b0; bus.op = op; bus.is_8_bit = w8;
        bus.value = val; bus.count = cnt; bus.flags_in = flg;
        @(posedge clk); #2;
        bus.start = poke; bus.value = poke ? 16'hFFFF : ~val; bus.count = poke ? 8'd1 : cnt;
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 2) bus.start = 1'b0;
            if (bus.done) begin seen = 1'b1; lat = i; end
        end
        bus.start = 1'b0;
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, {16'h0, bus.result}, {16'h0, exp_res});
        chk({name, " flags"}, {16'h0, bus.flags_out}, {16'h0, exp_flg});
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        chk("idle timeout", {31'b0, idle}, 32'h1);
    endtask

    initial begin
        bit seen;
        ops = '{OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR};
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = '0; bus.is_8_bit = 1'b0;
        bus.value = 16'h0; bus.count = 8'h0; bus.flags_in = 16'h0;
        #1 reset_n = 1'b0;
        #2;
        chk("reset busy", {31'b0, bus.busy}, 32'h0);
        chk("reset result", {16'h0, bus.result}, 32'h0);
        chk("reset alu_b", {16'h0, bus.alu_b}, 32'h1);
        @(posedge clk); #2 reset_n = 1'b1;

        chk("model ror8", ref_shift(OP_ROR, 1'b1, 16'h0081, 16'h0, 4), 32'h0000_0018);
        chk("model shl16", ref_shift(OP_SHL, 1'b0, 16'h8001, 16'h0, 3), 32'h0000_0008);
        chk("model rcr17", ref_shift(OP_RCR, 1'b0, 16'h0001, 16'h0, 17), 32'h0000_0001);

        run_dir("shl16", OP_SHL, 1'b0, 16'h8001, 8'd3,  16'h0000, 16'h0008, 16'h0000, 4, 1'b0);
        run_dir("ror8",  OP_ROR, 1'b1, 16'h0081, 8'd4,  16'h0000, 16'h0018, 16'h0000, 5, 1'b0);
        run_dir("cnt0",  OP_SHL, 1'b0, 16'h1234, 8'h00, 16'h0001, 16'h1234, 16'h0001, 1, 1'b0);
        run_dir("cnt21", OP_SHR, 1'b0, 16'h0002, 8'h21, 16'h0000, 16'h0001, 16'h0000, 2, 1'b0);
        run_dir("poke",  OP_ROL, 1'b0, 16'h8001, 8'd5,  16'h0000, 16'h0030, 16'h0000, 6, 1'b1);
        run_dir("rcl1",  OP_RCL, 1'b0, 16'h8000, 8'd1,  16'h0001, 16'h0001, 16'h0001, 2, 1'b0);

        // abort during the second RUN cycle of a 5-step shift
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = OP_SHL; bus.is_8_bit = 1'b0;
        bus.value = 16'h0001; bus.count = 8'd5; bus.flags_in = 16'h0;
        @(posedge clk); #2 bus.start = 1'b0;
        @(posedge clk); #2 bus.abort = 1'b1;
        @(posedge clk); #2 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort busy", {31'b0, bus.busy}, 32'h0);
        chk("abort partial", {16'h0, bus.alu_a}, 32'h0002);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("abort no done", {31'b0, seen}, 32'h0);

        // abort beats start while idle
        @(posedge clk); #2 bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("abort drops start", {31'b0, bus.busy}, 32'h0);

        // asynchronous reset in the middle of a long operation
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = OP_SHR; bus.value = 16'hF0F0; bus.count = 8'd10; bus.flags_in = 16'hFFFF;
        @(posedge clk); #2 bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, bus.busy}, 32'h0);
        chk("rst done", {31'b0, bus.done}, 32'h0);
        chk("rst result", {16'h0, bus.result}, 32'h0);
        chk("rst flags", {16'h0, bus.flags_out}, 32'h0);
        @(posedge clk); #2 reset_n = 1'b1;
        run_dir("after rst", OP_SAR, 1'b1, 16'h1281, 8'd2, 16'h00F0, 16'h12E0, 16'h00F0, 3, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            bus.start    = ($urandom % 3) == 0;
            bus.abort    = ($urandom % 25) == 0;
            bus.op       = ops[$urandom % 7];
            bus.is_8_bit = $urandom % 2;
            bus.value    = 16'($urandom);
            bus.flags_in = 16'($urandom);
            bus.count    = 8'($urandom);
        end
        @(posedge clk); #2 bus.start = 1'b0; bus.abort = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
- Multi-cycle controller that runs a multi-bit shift/rotate as a series of single-bit ALU shift/rotate operations.
- Drives the shared ALU operand, op, width and flags inputs, and captures the ALU result and flags each step.
- Sits between the microcode sequencer and the ALU for SHL/SHR/SAR/ROL/ROR/RCL/RCR with count in CL.
- CL is masked to 5 bits (80186 semantics), so a shift never takes more than 31 iteration cycles.

Parameters:
- OP_BITS, 5, width of the ALU op code; matches `MC_ALUOp_t_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a shift; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-flight shift (pipeline flush).
- op  in  OP_BITS  ALU shift/rotate op code; passed through unchanged, must be a shift/rotate op.
- is_8_bit  in  1  operand width for the whole operation.
- value  in  16  initial operand.
- count  in  8  shift count; only bits [4:0] are used.
- flags_in  in  16  initial flags.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  16  final value; valid from the done cycle until the next accepted start.
- flags_out  out  16  final flags; same validity as result.
- alu_a  out  16  ALU operand a; equals the working value register.
- alu_b  out  16  ALU operand b; constant 16'd1.
- alu_op  out  OP_BITS  latched op.
- alu_is_8_bit  out  1  latched width.
- alu_flags_in  out  16  working flags register.
- alu_out  in  16  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_flags_out  in  16  ALU flags result.

Behaviour:
- Reset (async, reset_n low): state=IDLE; busy=0; done=0; working value=0; working flags=0; remaining=0; latched op=0; latched width=0. Therefore result, flags_out, alu_a and alu_flags_in are 0.
- State machine: IDLE, RUN, DONE.
- IDLE with start=1 (accept edge, cycle T):
  - Latch op and is_8_bit; load working value from value and working flags from flags_in.
  - Set remaining = count[4:0].
  - If remaining is 0, go to DONE; otherwise go to RUN.
- IDLE with start=0: hold all registers.
- RUN, each cycle:
  - Load working value from alu_out and working flags from alu_flags_out.
  - Decrement remaining.
  - If remaining was 1, go to DONE; otherwise stay in RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE. Working value and flags are held.
- Latency:
  - done is asserted at cycle T+1+n, where n = count[4:0]; n=0 gives done at T+1.
  - Worst case is T+32.
- start while busy: ignored, with no queueing. A start in the same cycle as the DONE state is also ignored; it is accepted only when the block is in IDLE.
- abort:
  - In RUN or DONE: go to IDLE next cycle; done is not asserted (and is deasserted if abort arrives in DONE); registers keep their partial contents.
  - In IDLE: abort has priority over start; the start is dropped.
- alu_b is held at 1 in every state. alu_op and alu_is_8_bit remain at their latched values in IDLE.
- 8-bit mode:
  - Width handling (upper byte, flag positions) is the ALU's job.
  - The sequencer passes the full 16-bit alu_out straight through to result.
- Count bits [7:5] are ignored. Examples: 0x21 gives 1 step; 0x20 gives 0 steps.
- Reset mid-operation: returns immediately to the reset state; no done pulse.

Test Plan:
- SHL, 16-bit, value=0x8001, count=3, flags_in=0 -> done at T+4; result=0x0008; CF=0; busy high T+1..T+4.
- ROR, 8-bit, value=0x0081, count=4 -> done at T+5; result low byte=0x18.
- count=0x00, value=0x1234, flags_in=0x0001 -> done at T+1; result=0x1234; flags_out=0x0001; no RUN cycles; alu_out ignored.
- count=0x21, SHR, 16-bit, value=0x0002 -> exactly 1 step; done at T+2; result=0x0001.
- start pulsed during RUN with different value -> ignored, first result unchanged; abort at T+2 of a count=5 op -> IDLE at T+3, done never asserted.
- reset_n pulsed low asynchronously mid-RUN -> busy, done, result and flags_out read 0 immediately; the next start completes normally.
